// File: rtl/sr_cmd_scheduler.sv
// Round-robin scheduler sharing one SR flip-flop between N requesters.
// Each grant drives s/r for PULSE_CYC cycles, waits one settle cycle,
// then compares q against the value the command should have produced.
// s and r are never asserted together.
module sr_cmd_scheduler #(
   parameter int unsigned N         = 4,
   parameter int unsigned PULSE_CYC = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [2*N-1:0] cmd,
   input  logic           q,
   output logic           s,
   output logic           r,
   output logic [N-1:0]   gnt,
   output logic           done,
   output logic           err
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   localparam logic [1:0] CMD_RESET  = 2'b01;
   localparam logic [1:0] CMD_SET    = 2'b10;
   localparam logic [1:0] CMD_TOGGLE = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK, ST_DONE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, idx, win;
   logic [IW:0]   cand;
   logic          found;
   logic [1:0]    cmd_l;
   logic [1:0]    win_cmd;
   logic          qlat, exp_q;
   logic [CW-1:0] cnt;
   logic          any_req;
   logic          s_nxt, r_nxt, done_nxt, err_nxt;
   logic [N-1:0]  gnt_nxt;
   logic [1:0]    cmd_a [N];

   // {s,r} drive for a command; toggle flips relative to the latched q
   function automatic logic [1:0] sr_drive(input logic [1:0] c, input logic ql);
      case (c)
         CMD_SET:    sr_drive = 2'b10;
         CMD_RESET:  sr_drive = 2'b01;
         CMD_TOGGLE: sr_drive = ql ? 2'b01 : 2'b10;
         default:    sr_drive = 2'b00;
      endcase
   endfunction

   // q value the flip-flop should hold once the command has been applied
   function automatic logic q_expect(input logic [1:0] c, input logic ql);
      case (c)
         CMD_SET:    q_expect = 1'b1;
         CMD_RESET:  q_expect = 1'b0;
         CMD_TOGGLE: q_expect = ~ql;
         default:    q_expect = ql;
      endcase
   endfunction

   for (genvar gi = 0; gi < N; gi++) begin : g_cmd
      assign cmd_a[gi] = cmd[2*gi +: 2];
   end

   assign any_req = |req;
   assign win_cmd = cmd_a[win];

   // Round-robin winner: first set req bit scanning from ptr with wrap at N
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any_req) state_nxt = ST_DRIVE;
         ST_DRIVE: if (cnt == '0) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      s_nxt    = 1'b0;
      r_nxt    = 1'b0;
      gnt_nxt  = gnt;
      done_nxt = 1'b0;
      err_nxt  = err;
      case (state)
         ST_IDLE: begin
            gnt_nxt = '0;
            err_nxt = 1'b0;
            if (any_req) begin
               gnt_nxt[win]   = 1'b1;
               {s_nxt, r_nxt} = sr_drive(win_cmd, q);
            end
         end
         ST_DRIVE: if (cnt != '0) {s_nxt, r_nxt} = sr_drive(cmd_l, qlat);
         ST_CHECK: begin
            done_nxt = 1'b1;
            err_nxt  = (q != exp_q);
         end
         ST_DONE: begin
            gnt_nxt = '0;
            err_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s    <= 1'b0;
         r    <= 1'b0;
         gnt  <= '0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         s    <= s_nxt;
         r    <= r_nxt;
         gnt  <= gnt_nxt;
         done <= done_nxt;
         err  <= err_nxt;
      end
   end

   // Transaction context: latched at grant, pulse counter, pointer advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr   <= '0;
         idx   <= '0;
         cmd_l <= '0;
         qlat  <= 1'b0;
         exp_q <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (any_req) begin
               idx   <= win;
               cmd_l <= win_cmd;
               qlat  <= q;
               exp_q <= q_expect(win_cmd, q);
               cnt   <= CW'(PULSE_CYC - 1);
            end
            ST_DRIVE: if (cnt != '0) cnt <= cnt - CW'(1);
            ST_DONE:  ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_cmd_scheduler.sv
// Bench for sr_cmd_scheduler: two instances (PULSE_CYC=1 and 3) share the
// request stream; each drives its own modelled SR flip-flop. A transaction
// timeline model predicts every output each cycle.
`timescale 1ns/1ps
module tb_sr_cmd_scheduler;

   localparam int N  = 4;
   localparam int P0 = 1;
   localparam int P1 = 3;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [2*N-1:0] cmd;
   logic [1:0]     q_i, s_o, r_o, done_o, err_o;
   logic [1:0]     q_ff = 2'b00;
   logic [N-1:0]   gnt_o [2];
   logic           stuck;
   logic           cmp_en;
   int             checks;
   int             failures;

   // transaction timeline model per instance
   logic       m_act   [2];
   int         m_phase [2];
   int         m_win   [2];
   int         m_ptr   [2];
   logic [1:0] m_cmd   [2];
   logic       m_ql    [2];
   logic       m_err   [2];

   sr_cmd_scheduler #(.N(N), .PULSE_CYC(P0)) u_p1 (
      .clk(clk), .rst(rst), .req(req), .cmd(cmd), .q(q_i[0]),
      .s(s_o[0]), .r(r_o[0]), .gnt(gnt_o[0]), .done(done_o[0]), .err(err_o[0]));

   sr_cmd_scheduler #(.N(N), .PULSE_CYC(P1)) u_p3 (
      .clk(clk), .rst(rst), .req(req), .cmd(cmd), .q(q_i[1]),
      .s(s_o[1]), .r(r_o[1]), .gnt(gnt_o[1]), .done(done_o[1]), .err(err_o[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // external SR flip-flops, optionally stuck at 0
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (s_o[d])      q_ff[d] <= 1'b1;
         else if (r_o[d]) q_ff[d] <= 1'b0;
      end
   end
   assign q_i = stuck ? 2'b00 : q_ff;

   function automatic int pc(input int d);
      return (d == 0) ? P0 : P1;
   endfunction

   function automatic int rr_pick(input int p, input logic [N-1:0] rq);
      for (int k = 0; k < N; k++)
         if (rq[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   function automatic logic [1:0] sr_rule(input logic [1:0] c, input logic ql);
      case (c)
         2'b10:   return 2'b10;
         2'b01:   return 2'b01;
         2'b11:   return ql ? 2'b01 : 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic q_goal(input logic [1:0] c, input logic ql);
      case (c)
         2'b10:   return 1'b1;
         2'b01:   return 1'b0;
         2'b11:   return !ql;
         default: return ql;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // model: grant at an idle edge, phases count edges since grant
   always @(posedge clk or negedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            m_act[d]   <= 1'b0;
            m_phase[d] <= 0;
            m_win[d]   <= 0;
            m_ptr[d]   <= 0;
            m_cmd[d]   <= 2'b00;
            m_ql[d]    <= 1'b0;
            m_err[d]   <= 1'b0;
         end else if (!m_act[d]) begin
            if (req != '0) begin
               m_act[d]   <= 1'b1;
               m_phase[d] <= 0;
               m_win[d]   <= rr_pick(m_ptr[d], req);
               m_cmd[d]   <= cmd[2*rr_pick(m_ptr[d], req) +: 2];
               m_ql[d]    <= q_i[d];
            end
         end else begin
            m_phase[d] <= m_phase[d] + 1;
            if (m_phase[d] + 1 == pc(d) + 1)
               m_err[d] <= (q_i[d] != q_goal(m_cmd[d], m_ql[d]));
            if (m_phase[d] + 1 == pc(d) + 2) begin
               m_act[d] <= 1'b0;
               m_ptr[d] <= (m_win[d] + 1) % N;
            end
         end
      end
   end

   // every-cycle comparison against the model plus invariants
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int d = 0; d < 2; d++) begin
            logic [N-1:0] eg;
            logic [1:0]   esr;
            logic         ed;
            eg = '0;
            if (m_act[d]) eg[m_win[d]] = 1'b1;
            esr = (m_act[d] && m_phase[d] < pc(d)) ? sr_rule(m_cmd[d], m_ql[d]) : 2'b00;
            ed  = m_act[d] && (m_phase[d] == pc(d) + 1);
            chk($sformatf("p%0d_gnt", d), 32'(gnt_o[d]), 32'(eg));
            chk($sformatf("p%0d_sr", d), 32'({s_o[d], r_o[d]}), 32'(esr));
            chk($sformatf("p%0d_done", d), 32'(done_o[d]), 32'(ed));
            if (ed) chk($sformatf("p%0d_err", d), 32'(err_o[d]), 32'(m_err[d]));
            chk($sformatf("p%0d_inv_s_and_r", d), 32'(s_o[d] & r_o[d]), 32'(0));
            chk($sformatf("p%0d_inv_gnt_onehot0", d), 32'($onehot0(gnt_o[d])), 32'(1));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic quiesce();
      req = '0;
      repeat (10) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // one command on the PULSE_CYC=1 instance; returns s/r of first drive cycle and err
   task automatic run_txn(input int who, input logic [1:0] c,
                          output logic s_at, output logic r_at, output logic e_at);
      int n;
      cmd[2*who +: 2] = c;
      req = '0;
      req[who] = 1'b1;
      n = 0;
      tick();
      while (gnt_o[0] == '0 && n < 20) begin tick(); n++; end
      chk("txn_gnt_seen", 32'(gnt_o[0] != '0), 32'(1));
      chk("txn_gnt_who", 32'(gnt_o[0]), 32'(1) << who);
      s_at = s_o[0];
      r_at = r_o[0];
      n = 0;
      while (!done_o[0] && n < 20) begin tick(); n++; end
      chk("txn_done_seen", 32'(done_o[0]), 32'(1));
      e_at = err_o[0];
      req = '0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic         sa, ra, ea;
      logic [N-1:0] seq [5];
      logic [N-1:0] prev;
      int           n, cyc;

      checks   = 0;
      failures = 0;
      cmp_en   = 1'b0;
      stuck    = 1'b0;
      req      = '0;
      cmd      = '0;
      rst      = 1'b1;
      #1 rst   = 1'b0;
      #1 cmp_en = 1'b1;

      // reset values under random inputs
      repeat (3) begin
         req = N'($urandom);
         cmd = (2*N)'($urandom);
         tick();
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_p%0d_s", d), 32'(s_o[d]), 0);
            chk($sformatf("rst_p%0d_r", d), 32'(r_o[d]), 0);
            chk($sformatf("rst_p%0d_gnt", d), 32'(gnt_o[d]), 0);
            chk($sformatf("rst_p%0d_done", d), 32'(done_o[d]), 0);
            chk($sformatf("rst_p%0d_err", d), 32'(err_o[d]), 0);
         end
      end

      // first transaction after release: SET from requester 0
      rst = 1'b1;
      req = 4'b0001;
      cmd = {6'($urandom), 2'b10};
      tick();
      chk("first_gnt", 32'(gnt_o[0]), 32'h1);
      chk("first_s", 32'(s_o[0]), 1);
      chk("first_r", 32'(r_o[0]), 0);
      tick();
      chk("first_s_off", 32'(s_o[0]), 0);
      chk("first_gnt_held", 32'(gnt_o[0]), 32'h1);
      chk("first_no_done_yet", 32'(done_o[0]), 0);
      tick();
      chk("first_done", 32'(done_o[0]), 1);
      chk("first_err", 32'(err_o[0]), 0);
      chk("first_q", 32'(q_i[0]), 1);
      req = '0;
      quiesce();

      // round-robin with all requesters held
      do_reset();
      cmd  = 8'hAA;
      req  = 4'hF;
      n    = 0;
      cyc  = 0;
      prev = '0;
      while (n < 5 && cyc < 60) begin
         tick();
         cyc++;
         if (prev == '0 && gnt_o[0] != '0) begin
            seq[n] = gnt_o[0];
            n++;
         end
         prev = gnt_o[0];
      end
      chk("rr_grant_count", 32'(n), 5);
      for (int i = 0; i < n; i++)
         chk($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(1) << (i % N));
      quiesce();

      // toggle from q=0 and back
      run_txn(0, 2'b01, sa, ra, ea);
      chk("pre_reset_err", 32'(ea), 0);
      chk("pre_reset_q", 32'(q_i[0]), 0);
      run_txn(1, 2'b11, sa, ra, ea);
      chk("tog1_s", 32'(sa), 1);
      chk("tog1_r", 32'(ra), 0);
      chk("tog1_err", 32'(ea), 0);
      chk("tog1_q", 32'(q_i[0]), 1);
      run_txn(2, 2'b11, sa, ra, ea);
      chk("tog2_s", 32'(sa), 0);
      chk("tog2_r", 32'(ra), 1);
      chk("tog2_err", 32'(ea), 0);
      chk("tog2_q", 32'(q_i[0]), 0);
      quiesce();

      // error detect with q stuck at 0
      stuck = 1'b1;
      run_txn(0, 2'b10, sa, ra, ea);
      chk("stuck_set_err", 32'(ea), 1);
      run_txn(0, 2'b01, sa, ra, ea);
      chk("stuck_reset_err", 32'(ea), 0);
      stuck = 1'b0;
      quiesce();

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         req   = N'($urandom);
         cmd   = (2*N)'($urandom);
         stuck = ($urandom_range(0, 15) == 0);
         tick();
      end
      stuck = 1'b0;
      quiesce();

      // async reset in the second DRIVE cycle of the PULSE_CYC=3 instance
      req = 4'b0001;
      cmd = 8'hAA;
      tick();
      chk("ar_s_first", 32'(s_o[1]), 1);
      tick();
      chk("ar_s_second", 32'(s_o[1]), 1);
      chk("ar_gnt_second", 32'(gnt_o[1]), 32'h1);
      rst = 1'b0;
      #1;
      chk("ar_s_dropped", 32'(s_o[1]), 0);
      chk("ar_gnt_dropped", 32'(gnt_o[1]), 0);
      chk("ar_done_low", 32'(done_o[1]), 0);
      tick();
      rst = 1'b1;
      req = 4'b1010;
      tick();
      chk("ar_regrant_p3", 32'(gnt_o[1]), 32'h2);
      chk("ar_regrant_p1", 32'(gnt_o[0]), 32'h2);
      quiesce();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_cmd_scheduler.md
# sr_cmd_scheduler

Round-robin command scheduler that shares one SR flip-flop between N requesters. Each requester posts a 2-bit command (hold/reset/set/toggle); the block grants one requester at a time and drives the flip-flop's s/r inputs for a fixed pulse. It then checks the flip-flop's q feedback against the expected value and returns a done/err handshake. The block never drives s=r=1, so the forbidden SR input combination cannot reach the shared flip-flop.

## Interface
- N, default 4: number of requesters; legal range N >= 2.
- PULSE_CYC, default 1: number of cycles s or r is held high per command; legal range PULSE_CYC >= 1.

- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- req, input, N: request per requester; held high until done is seen with the matching gnt bit.
- cmd, input, 2*N: command of requester i at cmd[2i+1:2i]. Encodings: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- q, input, 1: q feedback from the shared SR flip-flop.
- s, output, 1: set drive to the flip-flop.
- r, output, 1: reset drive to the flip-flop.
- gnt, output, N: one-hot grant, held from the grant edge through the DONE cycle.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: valid only while done=1. High when q does not match the expected value.

## Operation
- Reset (rst=0, asynchronous) forces the following immediately, regardless of clk:
  - state=IDLE; s=r=0; gnt=0; done=0; err=0.
  - pointer ptr=0; latched index, latched command, latched q (qlat) and expected value all 0.
- State machine: IDLE -> DRIVE -> CHECK -> DONE -> IDLE.
- IDLE:
  - s=r=0, gnt=0.
  - If any req bit is set at the rising edge, the winner is the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On that edge, latch the winner index, its cmd, and qlat=q. Assert gnt[winner], load the pulse counter with PULSE_CYC-1, and go to DRIVE.
  - If req=0, stay in IDLE.
- DRIVE, for PULSE_CYC cycles, drives s/r from the latched command and qlat:
  - SET: s=1, r=0.
  - RESET: s=0, r=1.
  - TOGGLE: s=~qlat, r=qlat.
  - HOLD: s=0, r=0.
  - The counter decrements each cycle; at 0 the FSM goes to CHECK.
- CHECK: one cycle with s=r=0 for settling. At the exit edge, register err = (q != expected):
  - SET: expected=1.
  - RESET: expected=0.
  - TOGGLE: expected=~qlat.
  - HOLD: expected=qlat.
- DONE: one cycle with done=1 and gnt still asserted. At the exit edge, ptr = (winner+1) mod N, gnt clears, and the FSM goes to IDLE.
- Latched command: the transaction runs to completion even if req or cmd change or drop after the grant edge. req/cmd changes are ignored until IDLE.
- Invariants:
  - s&r is never 1.
  - At most one gnt bit is high.
  - s and r are 0 outside DRIVE.
  - done is high only in DONE.
- Width rules: ptr and the winner index are clog2(N) bits. The wrap from N-1 goes to 0, including non-power-of-two N.
- Outputs are registered (Moore): s, r, gnt, done and err are driven from state registers with no combinational path from req or cmd.

## Timing
- Grant latency: req sampled high at edge k while in IDLE gives gnt high from k through the DONE cycle. s/r are active in cycles k..k+PULSE_CYC-1.
- done is high in the cycle starting at edge k+PULSE_CYC+1.
- Transaction length: PULSE_CYC+2 cycles. The next arbitration occurs at the earliest one IDLE cycle later.
- Back-to-back throughput: one command per PULSE_CYC+3 cycles.
- Requester protocol:
  - On seeing done=1 and its gnt bit, the requester deasserts req at the next edge; the controller's following IDLE cycle therefore sees it low.
  - A requester that keeps req high is treated as a new request and competes under round-robin.
- Simultaneous requests: resolved purely by ptr. No requester waits more than N-1 transactions.
- Reset mid-transaction: s, r, gnt and done drop asynchronously, with no done pulse for the aborted command. After rst rises, the first arbitration starts from ptr=0.

## Test plan
- Reset values: hold rst=0 with random req/cmd -> s=r=0, gnt=0, done=0, err=0. After release with req=0001, cmd[1:0]=10 and PULSE_CYC=1:
  - grant at the first edge: gnt=0001, s=1 for 1 cycle;
  - done=1 two cycles after the grant edge;
  - q=1 and err=0.
- Round-robin: req=1111 held continuously with all cmd=SET -> gnt sequence 0001, 0010, 0100, 1000, 0001, with one done per requester and ptr wrapping 3->0.
- Toggle: with q=0, one TOGGLE -> s=1, r=0 and final q=1. A second TOGGLE -> r=1, s=0, q=0. err=0 on both.
- Never-forbidden check: random req/cmd for 2000 cycles with N=4 and PULSE_CYC=3 -> s&r is never 1, and gnt is always one-hot or zero.
- Error detect: force q stuck at 0 and issue SET -> err=1 in the done cycle. Issue RESET -> err=0.
- Async reset mid-DRIVE: with PULSE_CYC=3, assert rst=0 in the 2nd DRIVE cycle -> s and gnt go 0 before the next edge, and no done pulse occurs. After release, req=1010 -> gnt=0010 first.
